// File: rtl/uart_pkg.sv
// Shared UART receive-side types: sequencer state encoding and byte width.
package uart_pkg;
  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RESYNC   = 2'd1,
    ST_RUN      = 2'd2
  } rx_state_e;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Downstream byte stream out of the receive sequencer (valid/ready).
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic [UART_BYTE_W-1:0] m_data;
  logic                   m_valid;
  logic                   m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// Small synchronous FIFO; pop is resolved before push so a full FIFO
// with a simultaneous pop still accepts the incoming word.
module sync_fifo #(
  parameter int AW = 3,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    pop_ok, push_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for one uart_rx: sample-tick divider, uart_rx reset ownership,
// byte capture into a FIFO, overrun flag and line-idle timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DivW   = 16,
  parameter int FifoAW = 3,
  parameter int IdleW  = 8
) (
  input  logic                   ref_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [DivW-1:0]        div,
  input  logic [IdleW-1:0]       idle_lim,
  output logic                   rx_samp,
  output logic                   rx_reset,
  input  logic                   rx_ready,
  input  logic [UART_BYTE_W-1:0] rx_data,
  uart_rx_ctrl_if.master         m_if,
  output logic [FifoAW:0]        level,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic                   idle
);
  rx_state_e              state, state_nx;
  logic [DivW-1:0]        cnt, div_q;
  logic                   pcnt;
  logic [1:0]             rdy_pipe;
  logic [UART_BYTE_W-1:0] data_q;
  logic [IdleW-1:0]       icnt, icnt_nx;
  logic                   run, push, drop, flush, full, empty;

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_DISABLED;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_samp  = 1'b0;
    rx_reset = 1'b1;
    if (state != ST_DISABLED) rx_samp = (cnt == div_q);
    case (state)
      ST_DISABLED: if (enable) state_nx = ST_RESYNC;
      ST_RESYNC:   if (rx_samp && pcnt) state_nx = ST_RUN;
      ST_RUN:      rx_reset = 1'b0;
      default:     state_nx = ST_DISABLED;
    endcase
    if (!enable) state_nx = ST_DISABLED;
  end

  // div is tracked while disabled so the value present on entry to RESYNC is kept
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= '0;
      pcnt  <= 1'b0;
    end else begin
      if (state == ST_DISABLED) div_q <= div;
      if (state == ST_DISABLED || !enable) cnt <= '0;
      else if (rx_samp)                    cnt <= '0;
      else                                 cnt <= cnt + 1'b1;
      if (state != ST_RESYNC) pcnt <= 1'b0;
      else if (rx_samp)       pcnt <= 1'b1;
    end
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_pipe <= '0;
      data_q   <= '0;
    end else begin
      rdy_pipe <= {rdy_pipe[0], rx_ready};
      data_q   <= rx_data;
    end
  end

  assign run   = (state == ST_RUN);
  assign push  = rdy_pipe[0] & ~rdy_pipe[1] & run & enable;
  assign flush = ~enable | (state == ST_DISABLED);
  // a full FIFO can only be relieved by a same-cycle pop
  assign drop  = push & full & ~m_if.m_ready;

  sync_fifo #(.AW(FifoAW), .W(UART_BYTE_W)) u_fifo (
    .clk   (ref_clk),
    .rst_n (reset_n),
    .flush (flush),
    .push  (push),
    .pop   (m_if.m_ready),
    .wdata (data_q),
    .rdata (m_if.m_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign m_if.m_valid = ~empty;

  assign icnt_nx = icnt + 1'b1;

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
      icnt    <= '0;
      idle    <= 1'b0;
    end else begin
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      if (!run || idle_lim == '0 || push)    icnt <= '0;
      else if (rx_samp && icnt < idle_lim)   icnt <= icnt_nx;
      // counter saturates at idle_lim, so the pulse fires once per silence
      idle <= run & ~push & rx_samp & (icnt < idle_lim) & (icnt_nx == idle_lim);
    end
  end
endmodule
